// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard front end of the 2048 game.
//   - Scancode bytes used by the direction decoder (extended prefix, break
//     prefix, the four arrow keys and the 'S' start key).
//   - Bit positions of each direction inside the 4-bit {up,down,left,right}
//     request/held vectors.
//   - State encodings for the frame receiver and the scancode decoder.
//   - arrow_mask(): maps an arrow scancode to its one-hot direction mask.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_S     = 8'h1B;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        FRAME_IDLE,
        FRAME_DATA,
        FRAME_PARITY,
        FRAME_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    // Returns the one-hot direction mask for an arrow scancode, or zero when
    // the byte is not one of the four arrow keys.
    function automatic logic [3:0] arrow_mask(input logic [7:0] sc);
        logic [3:0] mask;
        mask = '0;
        case (sc)
            SC_UP:    mask[DIR_UP]    = 1'b1;
            SC_DOWN:  mask[DIR_DOWN]  = 1'b1;
            SC_LEFT:  mask[DIR_LEFT]  = 1'b1;
            SC_RIGHT: mask[DIR_RIGHT] = 1'b1;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Receives device-to-host PS/2 frames (start, 8 data bits LSB first, odd
// parity, stop) and presents each good byte as a one-cycle code_valid pulse.
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high
//   ps2_clk     in   PS/2 clock from the keyboard (asynchronous)
//   ps2_dat     in   PS/2 data from the keyboard (asynchronous)
//   code        out  last good byte received
//   code_valid  out  one-cycle pulse, code has just been updated
//   frame_err   out  one-cycle pulse on parity, stop or timeout failure
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TIMEOUT_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    frame_state_t  state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [TW-1:0] timer, timer_next;
    logic [7:0]    code_next;
    logic          code_valid_next;
    logic          frame_err_next;

    // Synchronisers reset to 1 because an idle PS/2 bus floats high.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // The filtered clock only follows the synchronised clock once it has
    // disagreed for FILTER_LEN consecutive samples; any agreeing sample
    // restarts the count, so short glitches never reach the frame FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Strobe fires in the same cycle the filtered clock is about to fall.
    assign strobe = filt_clk & ~clk_s & (filt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FRAME_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            timer      <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            timer      <= timer_next;
            code       <= code_next;
            code_valid <= code_valid_next;
            frame_err  <= frame_err_next;
        end
    end

    // One frame step per strobe. The gap timer runs only inside a frame and
    // is restarted by every strobe; expiry aborts the frame like any other
    // framing error.
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift_reg;
        timer_next      = timer;
        code_next       = code;
        code_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state)
            FRAME_IDLE: begin
                timer_next = '0;
                if (strobe && !dat_s) begin
                    state_next   = FRAME_DATA;
                    bit_cnt_next = '0;
                end
            end
            FRAME_DATA: begin
                if (strobe) begin
                    shift_next   = {dat_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = FRAME_PARITY;
                    end
                end
            end
            FRAME_PARITY: begin
                if (strobe) begin
                    if ((^shift_reg) ^ dat_s) begin
                        state_next = FRAME_STOP;
                    end else begin
                        state_next     = FRAME_IDLE;
                        frame_err_next = 1'b1;
                    end
                end
            end
            FRAME_STOP: begin
                if (strobe) begin
                    state_next = FRAME_IDLE;
                    if (dat_s) begin
                        code_next       = shift_reg;
                        code_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = FRAME_IDLE;
            end
        endcase

        if (state != FRAME_IDLE) begin
            if (strobe) begin
                timer_next = '0;
            end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                timer_next     = '0;
                state_next     = FRAME_IDLE;
                frame_err_next = 1'b1;
            end else begin
                timer_next = timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_direction_rx.sv
// ps2_direction_rx
// PS/2 keyboard front end for the 2048 game. Decodes make/break scancodes
// into arrow-key direction requests and a start request, held sticky until
// the slow game domain acknowledges them.
// Ports:
//   clock       in   system clock (CLOCK_50)
//   reset       in   synchronous, active-high
//   ps2_clk     in   PS/2 clock from the keyboard (asynchronous)
//   ps2_dat     in   PS/2 data from the keyboard (asynchronous)
//   dir_ack     in   one-cycle pulse, clears dir_req and start_req
//   dir_req     out  sticky one-hot request {up,down,left,right}
//   dir_held    out  arrows currently held down, same bit order
//   start_req   out  sticky request set by the 'S' make code
//   code        out  last good scancode byte
//   code_valid  out  one-cycle pulse, code updated
//   frame_err   out  one-cycle pulse on a framing failure
module ps2_direction_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       dir_ack,
    output logic [3:0] dir_req,
    output logic [3:0] dir_held,
    output logic       start_req,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    dec_state_t dec_state, dec_next;
    logic [3:0] req_next;
    logic [3:0] held_next;
    logic       start_next;
    logic [3:0] arrow;

    ps2_frame_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) u_frame_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_state <= DEC_BASE;
            dir_req   <= '0;
            dir_held  <= '0;
            start_req <= 1'b0;
        end else begin
            dec_state <= dec_next;
            dir_req   <= req_next;
            dir_held  <= held_next;
            start_req <= start_next;
        end
    end

    // The acknowledge clear is applied first so that a make arriving in the
    // same cycle overwrites it and the new request survives. A make for an
    // arrow already held is a typematic repeat and is ignored.
    always_comb begin
        dec_next   = dec_state;
        req_next   = dir_ack ? 4'b0000 : dir_req;
        start_next = dir_ack ? 1'b0 : start_req;
        held_next  = dir_held;
        arrow      = arrow_mask(code);

        if (code_valid) begin
            case (dec_state)
                DEC_BASE: begin
                    if (code == SC_EXT) begin
                        dec_next = DEC_EXT;
                    end else if (code == SC_BRK) begin
                        dec_next = DEC_BRK;
                    end else if (code == SC_S) begin
                        start_next = 1'b1;
                    end
                end
                DEC_EXT: begin
                    dec_next = DEC_BASE;
                    if (code == SC_BRK) begin
                        dec_next = DEC_EXT_BRK;
                    end else if ((arrow != 4'b0000) && ((dir_held & arrow) == 4'b0000)) begin
                        req_next  = arrow;
                        held_next = dir_held | arrow;
                    end
                end
                DEC_BRK: begin
                    dec_next = DEC_BASE;
                end
                DEC_EXT_BRK: begin
                    dec_next  = DEC_BASE;
                    held_next = dir_held & ~arrow;
                end
                default: begin
                    dec_next = DEC_BASE;
                end
            endcase
        end else if (frame_err) begin
            // A broken frame loses any half-received prefix sequence.
            dec_next = DEC_BASE;
        end
    end

endmodule
